// File: rtl/count_monitor.sv
// count_monitor: resynchronises a free-running 2-bit counter {q2,q1} into
// the clk domain and checks that every observed change is a +1 step mod 4.
// Good steps and sequence errors are counted, a stall is flagged after
// TIMEOUT quiet cycles, and a sticky FAULT is entered after ERR_LIMIT errors.
module count_monitor #(
   parameter int TIMEOUT   = 16,
   parameter int ERR_LIMIT = 4,
   parameter int ERR_W     = 8,
   parameter int EVT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             q2,
   input  logic             q1,
   input  logic             en,
   input  logic             clr,
   output logic [1:0]       cnt_val,
   output logic             step,
   output logic             err,
   output logic             stall,
   output logic             fault,
   output logic [ERR_W-1:0] err_cnt,
   output logic [EVT_W-1:0] evt_cnt,
   output logic [1:0]       state
);

   localparam int TMR_W = $clog2(TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(TIMEOUT - 1);
   localparam logic [ERR_W-1:0] ERR_TRIP  = ERR_W'(ERR_LIMIT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   // Synchroniser stages
   logic [1:0]       r_sync1;
   logic [1:0]       r_sync2;

   // Monitor state
   state_t           r_state;
   logic [1:0]       r_prev;
   logic [TMR_W-1:0] r_timer;
   logic             r_stall;
   logic             r_step;
   logic             r_err;
   logic [ERR_W-1:0] r_err_cnt;
   logic [EVT_W-1:0] r_evt_cnt;

   // Next-state values
   state_t           w_state_nxt;
   logic [1:0]       w_prev_nxt;
   logic [TMR_W-1:0] w_timer_nxt;
   logic             w_stall_nxt;
   logic             w_step_nxt;
   logic             w_err_nxt;
   logic [ERR_W-1:0] w_err_cnt_nxt;
   logic [EVT_W-1:0] w_evt_cnt_nxt;

   // Derived values
   logic [1:0]       w_s;
   logic [1:0]       w_prev_inc;
   logic             w_change;
   logic [ERR_W-1:0] w_err_inc;

   assign w_s        = r_sync2;
   assign w_prev_inc = r_prev + 2'd1;
   assign w_change   = (w_s != r_prev);
   assign w_err_inc  = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + ERR_W'(1);

   // Two-flop synchroniser on the asynchronous counter bits
   // NOTE: the synchroniser flops are reset too, so cnt_val is a known 0
   // right after reset instead of whatever the counter happened to show.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1 <= 2'd0;
         r_sync2 <= 2'd0;
      end else begin
         r_sync1 <= {q2, q1};
         r_sync2 <= r_sync1;
      end
   end

   // Next-state and pulse/counter decisions for the monitor FSM
   always_comb begin
      // NOTE: every output of this block gets a default first; otherwise a
      // branch that skips an assignment would infer a latch.
      w_state_nxt   = r_state;
      w_prev_nxt    = r_prev;
      w_timer_nxt   = r_timer;
      w_stall_nxt   = r_stall;
      w_step_nxt    = 1'b0;
      w_err_nxt     = 1'b0;
      w_err_cnt_nxt = r_err_cnt;
      w_evt_cnt_nxt = r_evt_cnt;

      if (clr) begin
         // clr beats en and any change detected on the same edge
         w_state_nxt   = IDLE;
         w_prev_nxt    = w_s;
         w_timer_nxt   = '0;
         w_stall_nxt   = 1'b0;
         w_err_cnt_nxt = '0;
         w_evt_cnt_nxt = '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               w_prev_nxt  = w_s;
               w_timer_nxt = '0;
               if (en) begin
                  w_state_nxt = TRACK;
               end
            end

            TRACK: begin
               if (!en) begin
                  // Leaving TRACK drops any pending change; counters kept
                  w_state_nxt = IDLE;
                  w_prev_nxt  = w_s;
                  w_timer_nxt = '0;
                  w_stall_nxt = 1'b0;
               end else if (w_change) begin
                  // Resync prev on every change so one glitch costs one error
                  w_prev_nxt  = w_s;
                  w_timer_nxt = '0;
                  w_stall_nxt = 1'b0;
                  if (w_s == w_prev_inc) begin
                     w_step_nxt    = 1'b1;
                     w_evt_cnt_nxt = r_evt_cnt + EVT_W'(1);
                  end else begin
                     w_err_nxt     = 1'b1;
                     w_err_cnt_nxt = w_err_inc;
                     if (w_err_inc >= ERR_TRIP) begin
                        w_state_nxt = FAULT;
                     end
                  end
               end else if (r_timer == TMR_MAX) begin
                  w_stall_nxt = 1'b1;
               end else begin
                  w_timer_nxt = r_timer + TMR_W'(1);
               end
            end

            FAULT: begin
               // Everything frozen; only clr or rst leaves this state
            end

            default: begin
               w_state_nxt = IDLE;
            end
         endcase
      end
   end

   // State, counter and pulse registers
   // NOTE: registers use non-blocking assignments so every flop samples the
   // pre-edge values; the combinational block above uses blocking ones.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_prev    <= 2'd0;
         r_timer   <= '0;
         r_stall   <= 1'b0;
         r_step    <= 1'b0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
         r_evt_cnt <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_prev    <= w_prev_nxt;
         r_timer   <= w_timer_nxt;
         r_stall   <= w_stall_nxt;
         r_step    <= w_step_nxt;
         r_err     <= w_err_nxt;
         r_err_cnt <= w_err_cnt_nxt;
         r_evt_cnt <= w_evt_cnt_nxt;
      end
   end

   assign cnt_val = w_s;
   assign step    = r_step;
   assign err     = r_err;
   assign stall   = r_stall;
   assign fault   = (r_state == FAULT);
   assign err_cnt = r_err_cnt;
   assign evt_cnt = r_evt_cnt;
   assign state   = r_state;

endmodule

// File: tb/tb_count_monitor.sv
// Directed testbench for count_monitor with hand-computed expectations.
module tb_count_monitor;

   localparam int ERR_W = 8;
   localparam int EVT_W = 16;

   logic             clk;
   logic             rst;
   logic             q2;
   logic             q1;
   logic             en;
   logic             clr;
   logic [1:0]       cnt_val;
   logic             step;
   logic             err;
   logic             stall;
   logic             fault;
   logic [ERR_W-1:0] err_cnt;
   logic [EVT_W-1:0] evt_cnt;
   logic [1:0]       state;

   int n_checks = 0;
   int n_errors = 0;

   // Results of the most recent drive_hold window
   int         step_n;
   int         err_n;
   int         step_at;
   int         err_at;
   int         unstall_at;
   logic [1:0] st_at_err;
   int         first_stall;

   count_monitor #(
      .TIMEOUT  (16),
      .ERR_LIMIT(4),
      .ERR_W    (ERR_W),
      .EVT_W    (EVT_W)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .q2     (q2),
      .q1     (q1),
      .en     (en),
      .clr    (clr),
      .cnt_val(cnt_val),
      .step   (step),
      .err    (err),
      .stall  (stall),
      .fault  (fault),
      .err_cnt(err_cnt),
      .evt_cnt(evt_cnt),
      .state  (state)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Run-time guard
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a counter value and observe n edges; index i counts edges since the change
   task automatic drive_hold(input logic [1:0] v, input int n);
      {q2, q1}   = v;
      step_n     = 0;
      err_n      = 0;
      step_at    = -1;
      err_at     = -1;
      unstall_at = -1;
      st_at_err  = 2'd0;
      for (int i = 1; i <= n; i++) begin
         tick();
         if (step) begin
            step_n++;
            if (step_at < 0) step_at = i;
         end
         if (err) begin
            err_n++;
            if (err_at < 0) begin
               err_at    = i;
               st_at_err = state;
            end
         end
         if (!stall && unstall_at < 0) unstall_at = i;
      end
   endtask

   initial begin
      logic [1:0] seq_up [4];
      logic [1:0] seq_bk [4];
      logic [1:0] seq_r  [5];
      seq_up = '{2'd1, 2'd2, 2'd3, 2'd0};
      seq_bk = '{2'd0, 2'd3, 2'd2, 2'd1};
      seq_r  = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2};

      rst = 1'b1; en = 1'b0; clr = 1'b0; {q2, q1} = 2'd0;
      repeat (3) tick();

      // Reset state
      check("rst_cnt_val", cnt_val, 0);
      check("rst_step",    step,    0);
      check("rst_err",     err,     0);
      check("rst_stall",   stall,   0);
      check("rst_fault",   fault,   0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_evt_cnt", evt_cnt, 0);
      check("rst_state",   state,   0);

      // Enter TRACK and walk 0->1->2->3->0
      rst = 1'b0; en = 1'b1;
      tick();
      check("track_entry", state, 1);
      foreach (seq_up[k]) begin
         drive_hold(seq_up[k], 4);
         check("up_step_n",  step_n,  1);
         check("up_step_at", step_at, 3);
         check("up_err_n",   err_n,   0);
         check("up_cnt_val", cnt_val, seq_up[k]);
      end
      check("up_evt_cnt", evt_cnt, 4);
      check("up_err_cnt", err_cnt, 0);
      check("up_stall",   stall,   0);

      // Skip 1->3 is an error, then 3->0 is a valid step
      drive_hold(2'd1, 4);
      check("pre_skip_step", step_n, 1);
      drive_hold(2'd3, 4);
      check("skip_err_n",  err_n,   1);
      check("skip_err_at", err_at,  3);
      check("skip_step_n", step_n,  0);
      check("skip_errcnt", err_cnt, 1);
      drive_hold(2'd0, 4);
      check("resync_step", step_n,  1);
      check("resync_evt",  evt_cnt, 6);

      // Dropping en keeps counters; re-entering TRACK restarts the stall timer
      en = 1'b0;
      tick();
      check("idle_state",   state,   0);
      check("idle_evt_cnt", evt_cnt, 6);
      check("idle_err_cnt", err_cnt, 1);
      en = 1'b1;
      first_stall = -1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (stall && first_stall < 0) first_stall = i;
      end
      check("stall_rise_at", first_stall, 17);
      check("stall_held",    stall,       1);
      drive_hold(2'd1, 4);
      check("stall_step_at",  step_at,    3);
      check("stall_fall_at",  unstall_at, 3);
      check("stall_evt_cnt",  evt_cnt,    7);

      // clr, then four backward changes drive the block into FAULT
      clr = 1'b1;
      tick();
      check("clr_state",   state,   0);
      check("clr_err_cnt", err_cnt, 0);
      check("clr_evt_cnt", evt_cnt, 0);
      clr = 1'b0;
      tick();
      foreach (seq_bk[k]) begin
         drive_hold(seq_bk[k], 4);
         check("bk_err_n",   err_n,   1);
         check("bk_err_cnt", err_cnt, k + 1);
      end
      check("fault_same_edge", st_at_err, 2);
      check("fault_level",     fault,     1);
      check("fault_state",     state,     2);

      // FAULT freezes everything and ignores en
      en = 1'b0;
      drive_hold(2'd2, 4);
      check("frz_pulses_a", step_n + err_n, 0);
      drive_hold(2'd0, 4);
      check("frz_pulses_b", step_n + err_n, 0);
      check("frz_state",    state,   2);
      check("frz_err_cnt",  err_cnt, 4);
      check("frz_evt_cnt",  evt_cnt, 0);
      en = 1'b1;
      clr = 1'b1;
      tick();
      check("unfault_state",   state,   0);
      check("unfault_fault",   fault,   0);
      check("unfault_err_cnt", err_cnt, 0);
      check("unfault_evt_cnt", evt_cnt, 0);
      clr = 1'b0;

      // clr on the edge where a valid change is detected
      tick();
      check("c5_track", state, 1);
      {q2, q1} = 2'd1;
      tick();
      tick();
      clr = 1'b1;
      tick();
      check("c5_no_step", step,    0);
      check("c5_evt_cnt", evt_cnt, 0);
      check("c5_state",   state,   0);
      clr = 1'b0;
      drive_hold(2'd1, 4);
      check("c5_after_pulses", step_n + err_n, 0);
      check("c5_after_evt",    evt_cnt, 0);
      check("c5_after_state",  state,   1);

      // Build evt_cnt=5, err_cnt=2, then reset mid-TRACK
      foreach (seq_r[k]) drive_hold(seq_r[k], 4);
      drive_hold(2'd0, 4);
      drive_hold(2'd2, 4);
      check("pre_rst_evt", evt_cnt, 5);
      check("pre_rst_err", err_cnt, 2);
      en = 1'b0; rst = 1'b1;
      tick();
      check("mid_rst_cnt_val", cnt_val, 0);
      check("mid_rst_pulses",  step | err, 0);
      check("mid_rst_stall",   stall,   0);
      check("mid_rst_fault",   fault,   0);
      check("mid_rst_err_cnt", err_cnt, 0);
      check("mid_rst_evt_cnt", evt_cnt, 0);
      check("mid_rst_state",   state,   0);
      rst = 1'b0;
      repeat (3) tick();
      check("post_rst_cnt_val", cnt_val, 2);
      check("post_rst_evt",     evt_cnt, 0);
      en = 1'b1;
      tick();
      check("post_rst_track", state, 1);
      drive_hold(2'd3, 4);
      check("post_rst_step_at", step_at, 3);
      check("post_rst_err_n",   err_n,   0);
      check("post_rst_evt_cnt", evt_cnt, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
